dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port data memory of the single-cycle MIPS core between the CPU load/store port (requester 0) and a loader/debug port (requester 1). It grants one access per cycle using round-robin priority, supports a bounded lock for atomic multi-access sequences, and routes the one-cycle-latency read data back to the requester that issued the read. It sits between the processor datapath (`dataadr`/`writedata`/`memwrite`) and the data memory inside `top`.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `MAX_LOCK`, 8, maximum consecutive cycles a locked owner may hold the memory (≥1)

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `r0_req`, `r1_req`  in  1  access request; held until granted
- `r0_we`, `r1_we`  in  1  1 = write, 0 = read
- `r0_lock`, `r1_lock`  in  1  request to keep ownership after this grant
- `r0_addr`, `r1_addr`  in  AW  byte address
- `r0_wdata`, `r1_wdata`  in  DW  write data
- `r0_gnt`, `r1_gnt`  out  1  access accepted this cycle
- `r0_rvalid`, `r1_rvalid`  out  1  read data valid (one cycle after read grant)
- `r0_rdata`, `r1_rdata`  out  DW  read data; meaningful only with rvalid
- `mem_en`, `mem_we`  out  1  memory access strobe / write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, valid the cycle after `mem_en` with `mem_we`=0

## Operation
- State: `prio` (1 bit, requester with priority), `own_v`/`own_id` (lock owner), `lock_cnt` (counts cycles owned, width clog2(MAX_LOCK+1)), `rd_pend_v`/`rd_pend_id` (read return tracking).
- Grant (combinational): if `own_v`, only `own_id` can be granted, and only if its req is high; otherwise if one req high, grant it; if both high, grant `prio`. At most one gnt high per cycle.
- Memory outputs: `mem_en` = any gnt; `mem_we`, `mem_addr`, `mem_wdata` muxed from granted requester; when no grant, `mem_en`=`mem_we`=0, addr/wdata = 0.
- Priority update: on any grant with no lock active after the cycle, `prio` ← other requester than the one granted.
- Lock: grant with that requester's lock=1 sets `own_v`=1, `own_id`, increments `lock_cnt` (from 0 on acquisition). Ownership ends when owner's lock=0 on a grant, when owner deasserts req for a cycle, or when `lock_cnt` reaches MAX_LOCK (forced release; prio ← other requester). After release `lock_cnt` ← 0.
- Read return: a read grant sets `rd_pend_v`=1, `rd_pend_id`; next cycle `rX_rvalid`=1 for that id only. `rX_rdata` = `mem_rdata` for both ports (unqualified).
- Writes produce no rvalid.

## Timing
- Reset (reset=0, async): `prio`=0, `own_v`=0, `lock_cnt`=0, `rd_pend_v`=0; while reset=0 all gnt, `mem_en`, `mem_we`, rvalid forced 0.
- Grant latency: 0 cycles (gnt same cycle as req if selected). Read latency: rvalid exactly 1 cycle after read gnt.
- Back-to-back grants every cycle allowed; reads in consecutive cycles give rvalid in consecutive cycles, each tagged correctly even when alternating requesters.
- Simultaneous req, no owner: `prio` wins; loser waits ≤1 cycle unless a lock forms (then ≤MAX_LOCK cycles).
- Reset asserted mid-read: pending rvalid is dropped; no rvalid after reset release until a new read grant.
- Reset release: first grant may occur in the first cycle reset=1.

## Test plan
- Reset: hold reset=0 with both req=1 → all gnt, mem_en, rvalid 0; release → first cycle r0_gnt=1 (prio=0).
- Contention: both req=1 for 4 cycles, no lock → gnt sequence r0,r1,r0,r1; mem_addr tracks granted port (r0_addr=0x50, r1_addr=0x54).
- Read routing: r1 reads 0x54 with memory returning 7 → r1_rvalid=1, r1_rdata=7 next cycle, r0_rvalid=0.
- Lock: r0 req+lock held, r1 req held, MAX_LOCK=8 → r0 granted 8 consecutive cycles, then r1_gnt=1 on cycle 9.
- Lock release: r0 lock for 2 grants then lock=0 on 3rd → r1 granted next cycle.
- Reset mid-read: r0 read grant, reset=0 next cycle → r0_rvalid stays 0; after release no spurious rvalid.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU (requester 0)
// and a loader/debug port (requester 1). It supports bounded locks and routes read returns.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_req,
    input  logic          r1_req,
    input  logic          r0_we,
    input  logic          r1_we,
    input  logic          r0_lock,
    input  logic          r1_lock,
    input  logic [AW-1:0] r0_addr,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r0_wdata,
    input  logic [DW-1:0] r1_wdata,
    output logic          r0_gnt,
    output logic          r1_gnt,
    output logic          r0_rvalid,
    output logic          r1_rvalid,
    output logic [DW-1:0] r0_rdata,
    output logic [DW-1:0] r1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW:0] LOCK_LIM = (CW+1)'(MAX_LOCK);

    typedef enum logic {OWN_NONE, OWN_HELD} own_state_e;

    own_state_e    own_state, own_state_n;
    logic          own_id, own_id_n;
    logic          prio, prio_n;
    logic [CW-1:0] lock_cnt, lock_cnt_n;
    logic          rd_pend_v, rd_pend_v_n;
    logic          rd_pend_id, rd_pend_id_n;

    logic          gnt0, gnt1, any_gnt, gnt_id, g_lock, g_we;
    logic [CW:0]   cnt_inc;

    // Grant selection; everything is held off while reset is asserted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset) begin
            if (own_state == OWN_HELD) begin
                if (own_id) gnt1 = r1_req;
                else        gnt0 = r0_req;
            end else if (r0_req && r1_req) begin
                if (prio) gnt1 = 1'b1;
                else      gnt0 = 1'b1;
            end else begin
                gnt0 = r0_req;
                gnt1 = r1_req;
            end
        end
    end

    assign any_gnt = gnt0 | gnt1;
    assign gnt_id  = gnt1;
    assign g_lock  = gnt1 ? r1_lock : r0_lock;
    assign g_we    = gnt1 ? r1_we : r0_we;
    assign cnt_inc = {1'b0, lock_cnt} + (CW+1)'(1);

    always_comb begin
        own_state_n  = own_state;
        own_id_n     = own_id;
        prio_n       = prio;
        lock_cnt_n   = lock_cnt;
        rd_pend_v_n  = any_gnt & ~g_we;
        rd_pend_id_n = gnt_id;
        if (any_gnt) begin
            if (g_lock && (cnt_inc < LOCK_LIM)) begin
                own_state_n = OWN_HELD;
                own_id_n    = gnt_id;
                lock_cnt_n  = cnt_inc[CW-1:0];
            end else begin
                // Voluntary unlock, plain grant, or lock budget exhausted.
                own_state_n = OWN_NONE;
                lock_cnt_n  = '0;
                prio_n      = ~gnt_id;
            end
        end else if (own_state == OWN_HELD) begin
            // Owner dropped its request: release and hand priority to the other side.
            own_state_n = OWN_NONE;
            lock_cnt_n  = '0;
            prio_n      = ~own_id;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            own_state  <= OWN_NONE;
            own_id     <= 1'b0;
            prio       <= 1'b0;
            lock_cnt   <= '0;
            rd_pend_v  <= 1'b0;
            rd_pend_id <= 1'b0;
        end else begin
            own_state  <= own_state_n;
            own_id     <= own_id_n;
            prio       <= prio_n;
            lock_cnt   <= lock_cnt_n;
            rd_pend_v  <= rd_pend_v_n;
            rd_pend_id <= rd_pend_id_n;
        end
    end

    assign r0_gnt    = gnt0;
    assign r1_gnt    = gnt1;
    assign mem_en    = any_gnt;
    assign mem_we    = any_gnt & g_we;
    assign mem_addr  = gnt1 ? r1_addr : (gnt0 ? r0_addr : '0);
    assign mem_wdata = gnt1 ? r1_wdata : (gnt0 ? r0_wdata : '0);

    assign r0_rvalid = reset & rd_pend_v & ~rd_pend_id;
    assign r1_rvalid = reset & rd_pend_v & rd_pend_id;
    assign r0_rdata  = mem_rdata;
    assign r1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural arbitration/memory model.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MAX_LOCK = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          r0_req = 0, r1_req = 0, r0_we = 0, r1_we = 0, r0_lock = 0, r1_lock = 0;
    logic [AW-1:0] r0_addr = '0, r1_addr = '0;
    logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
    logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_en, mem_we;
    logic [DW-1:0] r0_rdata, r1_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;

    int checks = 0;
    int failures = 0;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
        .r0_lock(r0_lock), .r1_lock(r1_lock),
        .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
        .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory environment ----------------
    logic [DW-1:0] env_mem [16];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) env_mem[mem_addr[5:2]] <= mem_wdata;
            else        mem_rdata <= env_mem[mem_addr[5:2]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    logic [DW-1:0] model_mem [16];
    logic [DW-1:0] exp_q [$];
    int  m_prio = 0, m_owner = -1, m_held = 0, m_pend_id = 0;
    bit  m_pend_v = 0;

    initial begin
        for (int i = 0; i < 16; i++) begin
            env_mem[i]   = DW'(i + 2);
            model_mem[i] = DW'(i + 2);
        end
    end

    initial begin
        logic          rq [2], we [2], lk [2];
        logic [AW-1:0] ad [2];
        logic [DW-1:0] wd [2];
        logic [DW-1:0] d;
        int w;
        forever begin
            @(negedge clk);
            #2;
            rq[0] = r0_req; rq[1] = r1_req; we[0] = r0_we; we[1] = r1_we;
            lk[0] = r0_lock; lk[1] = r1_lock; ad[0] = r0_addr; ad[1] = r1_addr;
            wd[0] = r0_wdata; wd[1] = r1_wdata;
            if (!reset) begin
                chk("rst_r0_gnt", 32'(r0_gnt), 0);
                chk("rst_r1_gnt", 32'(r1_gnt), 0);
                chk("rst_mem_en", 32'(mem_en), 0);
                chk("rst_mem_we", 32'(mem_we), 0);
                chk("rst_r0_rvalid", 32'(r0_rvalid), 0);
                chk("rst_r1_rvalid", 32'(r1_rvalid), 0);
                m_prio = 0; m_owner = -1; m_held = 0; m_pend_v = 0;
                exp_q.delete();
            end else begin
                if (m_owner >= 0)           w = rq[m_owner] ? m_owner : -1;
                else if (rq[0] && rq[1])    w = m_prio;
                else if (rq[0])             w = 0;
                else if (rq[1])             w = 1;
                else                        w = -1;

                chk("r0_gnt", 32'(r0_gnt), 32'(w == 0));
                chk("r1_gnt", 32'(r1_gnt), 32'(w == 1));
                chk("mem_en", 32'(mem_en), 32'(w >= 0));
                chk("mem_we", 32'(mem_we), 32'(w >= 0 && we[w]));
                chk("mem_addr", mem_addr, (w >= 0) ? ad[w] : 0);
                chk("mem_wdata", mem_wdata, (w >= 0) ? wd[w] : 0);

                chk("r0_rvalid", 32'(r0_rvalid), 32'(m_pend_v && m_pend_id == 0));
                chk("r1_rvalid", 32'(r1_rvalid), 32'(m_pend_v && m_pend_id == 1));
                if (m_pend_v) begin
                    d = exp_q.pop_front();
                    if (m_pend_id == 0) chk("r0_rdata", r0_rdata, d);
                    else                chk("r1_rdata", r1_rdata, d);
                end

                m_pend_v = (w >= 0) && !we[w];
                m_pend_id = w;
                if (w >= 0) begin
                    if (we[w]) model_mem[ad[w][5:2]] = wd[w];
                    else       exp_q.push_back(model_mem[ad[w][5:2]]);
                    if (lk[w]) begin
                        m_held = ((m_owner == w) ? m_held : 0) + 1;
                        if (m_held >= MAX_LOCK) begin
                            m_owner = -1; m_held = 0; m_prio = 1 - w;
                        end else begin
                            m_owner = w;
                        end
                    end else begin
                        m_owner = -1; m_held = 0; m_prio = 1 - w;
                    end
                end else if (m_owner >= 0) begin
                    m_prio = 1 - m_owner; m_owner = -1; m_held = 0;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_cycle(input logic rs,
                            input logic q0, input logic w0, input logic l0, input logic [AW-1:0] a0,
                            input logic q1, input logic w1, input logic l1, input logic [AW-1:0] a1);
        @(negedge clk);
        reset = rs;
        r0_req = q0; r0_we = w0; r0_lock = l0; r0_addr = a0; r0_wdata = $urandom;
        r1_req = q1; r1_we = w1; r1_lock = l1; r1_addr = a1; r1_wdata = $urandom;
        #1;
    endtask

    task automatic do_reset();
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic g0, g1;
        // Reset held with both requesting: nothing may be granted.
        do_cycle(0, 1, 0, 0, 32'h50, 1, 0, 0, 32'h54);
        chk("lit_rst_gnt", {30'd0, r0_gnt, r1_gnt}, 0);
        chk("lit_rst_mem_en", 32'(mem_en), 0);
        do_cycle(0, 1, 0, 0, 32'h50, 1, 0, 0, 32'h54);

        // Contention after release: r0, r1, r0, r1 with matching addresses.
        do_cycle(1, 1, 0, 0, 32'h50, 1, 0, 0, 32'h54);
        chk("lit_cont0_gnt", {30'd0, r0_gnt, r1_gnt}, 2);
        chk("lit_cont0_addr", mem_addr, 32'h50);
        do_cycle(1, 1, 0, 0, 32'h50, 1, 0, 0, 32'h54);
        chk("lit_cont1_gnt", {30'd0, r0_gnt, r1_gnt}, 1);
        chk("lit_cont1_addr", mem_addr, 32'h54);
        do_cycle(1, 1, 0, 0, 32'h50, 1, 0, 0, 32'h54);
        chk("lit_cont2_gnt", {30'd0, r0_gnt, r1_gnt}, 2);
        chk("lit_cont2_rv", {30'd0, r0_rvalid, r1_rvalid}, 1);
        do_cycle(1, 1, 0, 0, 32'h50, 1, 0, 0, 32'h54);
        chk("lit_cont3_gnt", {30'd0, r0_gnt, r1_gnt}, 1);
        chk("lit_cont3_rv", {30'd0, r0_rvalid, r1_rvalid}, 2);

        // Read routing: r1 reads 0x54, memory word there holds 7.
        do_reset();
        do_cycle(1, 0, 0, 0, 0, 1, 0, 0, 32'h54);
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_route_r1_rvalid", 32'(r1_rvalid), 1);
        chk("lit_route_r1_rdata", r1_rdata, 7);
        chk("lit_route_r0_rvalid", 32'(r0_rvalid), 0);

        // Lock to the budget: r0 holds eight cycles, r1 gets the ninth.
        do_reset();
        for (int i = 0; i < MAX_LOCK; i++) begin
            do_cycle(1, 1, 0, 1, 32'h10, 1, 0, 0, 32'h20);
            chk("lit_lock_hold", {30'd0, r0_gnt, r1_gnt}, 2);
        end
        do_cycle(1, 1, 0, 1, 32'h10, 1, 0, 0, 32'h20);
        chk("lit_lock_release", {30'd0, r0_gnt, r1_gnt}, 1);

        // Voluntary release on the third grant.
        do_reset();
        do_cycle(1, 1, 0, 1, 32'h10, 1, 0, 0, 32'h20);
        do_cycle(1, 1, 0, 1, 32'h10, 1, 0, 0, 32'h20);
        do_cycle(1, 1, 0, 0, 32'h10, 1, 0, 0, 32'h20);
        chk("lit_unlock_third", {30'd0, r0_gnt, r1_gnt}, 2);
        do_cycle(1, 1, 0, 0, 32'h10, 1, 0, 0, 32'h20);
        chk("lit_unlock_next", {30'd0, r0_gnt, r1_gnt}, 1);

        // Reset lands while a read is outstanding.
        do_reset();
        do_cycle(1, 1, 0, 0, 32'h08, 0, 0, 0, 0);
        chk("lit_midrd_gnt", 32'(r0_gnt), 1);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_midrd_rv_rst", {30'd0, r0_rvalid, r1_rvalid}, 0);
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_midrd_rv_rel", {30'd0, r0_rvalid, r1_rvalid}, 0);
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_midrd_rv_rel2", {30'd0, r0_rvalid, r1_rvalid}, 0);

        // Random traffic; requests stay stable until granted.
        g0 = 0; g1 = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 199) != 0);
            if (!(r0_req && !g0)) begin
                r0_req = ($urandom_range(0, 99) < 70);
                r0_we = $urandom_range(0, 1);
                r0_lock = ($urandom_range(0, 2) == 0);
                r0_addr = AW'($urandom_range(0, 15)) << 2;
                r0_wdata = $urandom;
            end
            if (!(r1_req && !g1)) begin
                r1_req = ($urandom_range(0, 99) < 70);
                r1_we = $urandom_range(0, 1);
                r1_lock = ($urandom_range(0, 2) == 0);
                r1_addr = AW'($urandom_range(0, 15)) << 2;
                r1_wdata = $urandom;
            end
            #1;
            g0 = r0_gnt; g1 = r1_gnt;
        end

        @(negedge clk);
        r0_req = 0; r1_req = 0;
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
